ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//   EX/MEM pipeline register plus data-memory access stage of the 5-stage MIPS core.
//   - Captures EX results and control on each clock edge.
//   - Performs sized, aligned load/store on an internal word-addressed data RAM.
//   - Presents WB control, ALU result, load data and destination register to the MEM/WB register downstream.
//   - Exports MEM-stage forwarding info to the forwarding unit.
// PARAMETERS
//   DEPTH      256   data RAM depth in 32-bit words (power of two)
//   ADDR_W     8     log2(DEPTH); word index = alu_result[ADDR_W+1:2]
// PORTS
//   clk            in   1   rising-edge clock
//   rst            in   1   synchronous, active-high reset
//   stall_i        in   1   hold EX/MEM contents; block store commit
//   flush_i        in   1   load a bubble into EX/MEM
//   WB_i           in   2   [1]=mem_2_reg, [0]=reg_write
//   mem_read_i     in   1   load
//   mem_write_i    in   1   store
//   size_i         in   2   00=byte, 01=half, 10=word, 11=reserved
//   unsigned_i     in   1   zero-extend byte/half loads (else sign-extend)
//   alu_result_i   in   32  effective address / ALU result
//   store_data_i   in   32  rt value for stores (low bytes used for sub-word)
//   rd_i           in   5   destination register
//   WB_o           out  2   registered WB_i, forced 0 on misaligned load
//   addr_o         out  32  registered alu_result (to MEM/WB addr_i)
//   data_o         out  32  load data, combinational from RAM (to MEM/WB data_i)
//   rd_o           out  5   registered rd_i (to MEM/WB ins_i)
//   fwd_regwrite_o out  1   WB_o[0] && !mem_read (ALU result forwardable)
//   misalign_o     out  1   access in MEM is misaligned or reserved size
// BEHAVIOUR
//   - Register priority at posedge clk: rst > flush_i > stall_i > load.
//   - Reset/flush: all EX/MEM fields cleared (bubble), so WB_o=0, addr_o=0, rd_o=0, data_o=0, misalign_o=0.
//   - RAM contents are NOT cleared by reset.
//   - Latency: inputs of cycle N appear on outputs during cycle N+1.
//     - Load data is combinational in N+1 and is captured by MEM/WB at the end of N+1.
//   - Store commit: RAM written at the posedge ending the MEM cycle, only when mem_write && !misalign && !stall_i && !rst.
//     - Exactly one write per store, however long the stall.
//   - Alignment: half needs addr[0]=0; word needs addr[1:0]=0; size 11 is always misaligned.
//     - Misaligned store: no write.
//     - Misaligned load: data_o=0 and WB_o forced to 0.
//     - misalign_o=1 in both cases.
//   - Byte lanes are little-endian.
//     - Byte lane = addr[1:0]; half lane = addr[1].
//     - Stores write only the selected lane(s), taking bits [7:0] or [15:0] of store_data_i.
//   - Load extension: byte/half are sign-extended unless unsigned_i was set; word is passed through.
//   - Address wrap: bits above ADDR_W+1 are ignored, so the word index wraps modulo DEPTH (no fault).
//   - data_o is 0 when the MEM op is not a load (keeps MEM/WB inputs deterministic).
//   - mem_read and mem_write both set: treated as a store; data_o=0.
//   - Back-to-back store then load to the same word: the load sees the new data (write committed at the shared edge).
//   - Flush while stalled: flush wins; a pending store is dropped, since stall_i blocks commit at that edge.
//   - Reset mid-store: no write occurs.
// STRUCTURE
//   Shared package cpu_pkg:
//     - SIZE_BYTE/SIZE_HALF/SIZE_WORD constants.
//     - WB field bit positions (WB_MEM2REG=1, WB_REGWRITE=0).
//   Sub-module dmem_bytelane:
//     - DEPTH x 32 RAM with 4-bit byte write enable, sync write, async read.
//     - Instantiated once.
//   Top level holds:
//     - EX/MEM registers.
//     - Alignment check.
//     - Lane/enable generation.
//     - Load extraction/extension.
// TESTING
//   1. Word store/load:
//      - Stimulus: sw 0xDEADBEEF @0x10, then lw @0x10 (unsigned_i=0).
//      - Required: data_o=0xDEADBEEF, WB_o=2'b11, rd_o as issued.
//   2. Byte lanes:
//      - Stimulus: sb 0x80 @0x13, then lb and lbu @0x13.
//      - Required: 0xFFFFFF80, then 0x00000080.
//      - Other bytes of the word are unchanged.
//   3. Misalign:
//      - Stimulus: sh @0x21, then lw @0x22.
//      - Required: misalign_o=1 both cycles; RAM word 0x20 unchanged; lw gives data_o=0, WB_o=0.
//   4. Stall:
//      - Stimulus: sw 0x1234 @0x40 with stall_i=1 for 3 cycles.
//      - Required: outputs held; one RAM write on release; a following lw returns 0x1234.
//   5. Flush/reset:
//      - Stimulus: flush_i=1 with a pending sw, then rst=1 mid-stream.
//      - Required: no write; all outputs 0 the next cycle; prior RAM data preserved.
//   6. Wrap:
//      - Stimulus: sw 0xA5A5A5A5 @(DEPTH*4+8), then lw @8.
//      - Required: data_o=0xA5A5A5A5.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: access sizes, WB field positions, EX/MEM payload.
package cpu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned WB_W  = 2;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    localparam int unsigned WB_MEM2REG  = 1;
    localparam int unsigned WB_REGWRITE = 0;

    typedef struct packed {
        logic [WB_W-1:0]  wb;
        logic             mem_read;
        logic             mem_write;
        logic [1:0]       size;
        logic             is_unsigned;
        logic [XLEN-1:0]  addr;
        logic [XLEN-1:0]  store_data;
        logic [REG_W-1:0] rd;
    } ex_mem_t;

    // Alignment rule: half on even bytes, word on 4-byte boundaries, reserved never.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = lsb[0];
            SIZE_WORD: bad = |lsb;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX -> MEM input bundle and MEM -> MEM/WB / forwarding outputs.
interface ex_mem_stage_if;
    import cpu_pkg::*;

    logic             stall_i;
    logic             flush_i;
    logic [WB_W-1:0]  WB_i;
    logic             mem_read_i;
    logic             mem_write_i;
    logic [1:0]       size_i;
    logic             unsigned_i;
    logic [XLEN-1:0]  alu_result_i;
    logic [XLEN-1:0]  store_data_i;
    logic [REG_W-1:0] rd_i;

    logic [WB_W-1:0]  WB_o;
    logic [XLEN-1:0]  addr_o;
    logic [XLEN-1:0]  data_o;
    logic [REG_W-1:0] rd_o;
    logic             fwd_regwrite_o;
    logic             misalign_o;

    modport master (
        output stall_i, flush_i, WB_i, mem_read_i, mem_write_i, size_i,
               unsigned_i, alu_result_i, store_data_i, rd_i,
        input  WB_o, addr_o, data_o, rd_o, fwd_regwrite_o, misalign_o
    );

    modport slave (
        input  stall_i, flush_i, WB_i, mem_read_i, mem_write_i, size_i,
               unsigned_i, alu_result_i, store_data_i, rd_i,
        output WB_o, addr_o, data_o, rd_o, fwd_regwrite_o, misalign_o
    );

endinterface

// File: rtl/dmem_bytelane.sv
// Word-organised data RAM with per-byte write enables, sync write, async read.
module dmem_bytelane #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    // Byte-lane write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register and data-memory access stage.
module ex_mem_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    ex_mem_stage_if.slave bus
);

    ex_mem_t     ex_d;
    ex_mem_t     q;
    logic        access;
    logic        is_load;
    logic        mis;
    logic        we;
    logic [3:0]  be;
    logic [3:0]  be_gated;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] load_val;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [WB_W-1:0] wb_out;

    // Pack EX-side inputs into the pipeline payload.
    always_comb begin
        ex_d             = '0;
        ex_d.wb          = bus.WB_i;
        ex_d.mem_read    = bus.mem_read_i;
        ex_d.mem_write   = bus.mem_write_i;
        ex_d.size        = bus.size_i;
        ex_d.is_unsigned = bus.unsigned_i;
        ex_d.addr        = bus.alu_result_i;
        ex_d.store_data  = bus.store_data_i;
        ex_d.rd          = bus.rd_i;
    end

    // EX/MEM register: reset > flush > stall > load.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (bus.flush_i) begin
            q <= '0;
        end else if (!bus.stall_i) begin
            q <= ex_d;
        end
    end

    assign access  = q.mem_read | q.mem_write;
    assign is_load = q.mem_read & ~q.mem_write;
    assign mis     = access & misaligned(q.size, q.addr[1:0]);

    // Byte-enable and lane-replicated write data for sub-word stores.
    always_comb begin
        be    = 4'b0000;
        wdata = q.store_data;
        case (q.size)
            SIZE_BYTE: begin
                be    = 4'b0001 << q.addr[1:0];
                wdata = {4{q.store_data[7:0]}};
            end
            SIZE_HALF: begin
                be    = q.addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{q.store_data[15:0]}};
            end
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
    end

    // Commit only once: a stalled store waits for the release edge.
    assign we       = q.mem_write & ~mis & ~bus.stall_i & ~rst;
    assign be_gated = we ? be : 4'b0000;

    dmem_bytelane #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dmem (
        .clk   (clk),
        .be    (be_gated),
        .addr  (q.addr[ADDR_W+1:2]),
        .wdata (wdata),
        .rdata (rdata)
    );

    // Lane extraction and sign/zero extension of load data.
    always_comb begin
        byte_sel = 8'h00;
        half_sel = q.addr[1] ? rdata[31:16] : rdata[15:0];
        case (q.addr[1:0])
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        case (q.size)
            SIZE_BYTE: load_val = q.is_unsigned ? {24'h0, byte_sel}
                                                : {{24{byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_val = q.is_unsigned ? {16'h0, half_sel}
                                                : {{16{half_sel[15]}}, half_sel};
            default:   load_val = rdata;
        endcase
    end

    assign wb_out             = (is_load & mis) ? '0 : q.wb;
    assign bus.WB_o           = wb_out;
    assign bus.addr_o         = q.addr;
    assign bus.rd_o           = q.rd;
    assign bus.data_o         = (is_load & ~mis) ? load_val : '0;
    assign bus.fwd_regwrite_o = wb_out[WB_REGWRITE] & ~q.mem_read;
    assign bus.misalign_o     = mis;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized self-checking bench for ex_mem_stage against a byte-array memory model.
module tb_ex_mem_stage;
    import cpu_pkg::*;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned MEMB  = DEPTH * 4;

    typedef struct packed {
        logic [1:0]  wb;
        logic        rd_en;
        logic        wr_en;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  rd;
    } op_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_mem_stage_if bus();

    ex_mem_stage #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference state: the op currently in MEM and a byte-addressed RAM image.
    op_t      mem_op;
    logic [7:0] ram [MEMB];
    op_t      cur_op;
    bit       cur_stall, cur_flush, cur_rst;
    int       checks = 0;
    int       errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        case (s)
            SIZE_BYTE: return 1;
            SIZE_HALF: return 2;
            SIZE_WORD: return 4;
            default:   return 0;
        endcase
    endfunction

    function automatic bit model_mis(input op_t o);
        int n;
        if (!(o.rd_en || o.wr_en)) return 1'b0;
        n = nbytes(o.size);
        if (n == 0) return 1'b1;
        return (o.addr % n) != 0;
    endfunction

    function automatic logic [31:0] model_load(input op_t o);
        int n;
        int base;
        logic [31:0] v;
        logic [31:0] ones;
        n    = nbytes(o.size);
        base = int'(o.addr % MEMB);
        v    = '0;
        ones = '1;
        for (int i = 0; i < n; i++) v = v | (32'(ram[base + i]) << (8 * i));
        if (!o.uns && n < 4 && v[8*n-1]) v = v | (ones << (8 * n));
        return v;
    endfunction

    function automatic op_t mk(input bit r, input bit w, input logic [1:0] sz, input bit u,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [4:0] rd, input logic [1:0] wb);
        op_t o;
        o.rd_en = r; o.wr_en = w; o.size = sz; o.uns = u;
        o.addr = a; o.sdata = d; o.rd = rd; o.wb = wb;
        return o;
    endfunction

    function automatic op_t sw(input logic [31:0] a, input logic [31:0] d);
        return mk(1'b0, 1'b1, SIZE_WORD, 1'b0, a, d, 5'd0, 2'b00);
    endfunction

    function automatic op_t lw(input logic [31:0] a, input logic [4:0] rd);
        logic [1:0] wb;
        wb = '0;
        wb[WB_MEM2REG]  = 1'b1;
        wb[WB_REGWRITE] = 1'b1;
        return mk(1'b1, 1'b0, SIZE_WORD, 1'b0, a, 32'h0, rd, wb);
    endfunction

    task automatic drive(input op_t o, input bit stall, input bit flush, input bit r);
        cur_op = o; cur_stall = stall; cur_flush = flush; cur_rst = r;
        rst              = r;
        bus.stall_i      = stall;
        bus.flush_i      = flush;
        bus.WB_i         = o.wb;
        bus.mem_read_i   = o.rd_en;
        bus.mem_write_i  = o.wr_en;
        bus.size_i       = o.size;
        bus.unsigned_i   = o.uns;
        bus.alu_result_i = o.addr;
        bus.store_data_i = o.sdata;
        bus.rd_i         = o.rd;
    endtask

    // Compare every output with what the spec rules predict for the op in MEM.
    task automatic check_all();
        bit          is_load, m;
        logic [1:0]  exp_wb;
        logic [31:0] exp_data;
        is_load  = mem_op.rd_en && !mem_op.wr_en;
        m        = model_mis(mem_op);
        exp_wb   = (is_load && m) ? 2'b00 : mem_op.wb;
        exp_data = (is_load && !m) ? model_load(mem_op) : 32'h0;
        check_eq("WB_o", 32'(bus.WB_o), 32'(exp_wb));
        check_eq("addr_o", bus.addr_o, mem_op.addr);
        check_eq("data_o", bus.data_o, exp_data);
        check_eq("rd_o", 32'(bus.rd_o), 32'(mem_op.rd));
        check_eq("fwd_regwrite_o", 32'(bus.fwd_regwrite_o), 32'(exp_wb[WB_REGWRITE] && !mem_op.rd_en));
        check_eq("misalign_o", 32'(bus.misalign_o), 32'(m));
    endtask

    // Advance one clock: apply the commit/priority rules to the model, then check.
    task automatic step();
        int n;
        int base;
        if (mem_op.wr_en && !model_mis(mem_op) && !cur_stall && !cur_rst) begin
            n    = nbytes(mem_op.size);
            base = int'(mem_op.addr % MEMB);
            for (int i = 0; i < n; i++) ram[base + i] = 8'(mem_op.sdata >> (8 * i));
        end
        if (cur_rst || cur_flush) mem_op = '0;
        else if (!cur_stall)      mem_op = cur_op;
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        op_t o;
        int  r;
        mem_op = '0;
        drive('0, 1'b0, 1'b0, 1'b1);
        step();
        step();
        check_eq("reset_addr", bus.addr_o, 32'h0);
        check_eq("reset_wb", 32'(bus.WB_o), 32'h0);

        // Give every RAM word a known value.
        for (int w = 0; w < int'(DEPTH); w++) begin
            drive(sw(32'(w * 4), $urandom), 1'b0, 1'b0, 1'b0);
            step();
        end

        // Word store then load.
        drive(sw(32'h10, 32'hDEADBEEF), 1'b0, 1'b0, 1'b0); step();
        drive(lw(32'h10, 5'd7), 1'b0, 1'b0, 1'b0); step();
        check_eq("t1_data", bus.data_o, 32'hDEADBEEF);
        check_eq("t1_wb", 32'(bus.WB_o), 32'h3);
        check_eq("t1_rd", 32'(bus.rd_o), 32'd7);

        // Byte lane store, signed and unsigned byte loads, neighbours intact.
        drive(mk(1'b0, 1'b1, SIZE_BYTE, 1'b0, 32'h13, 32'h12345680, 5'd0, 2'b00), 1'b0, 1'b0, 1'b0); step();
        drive(mk(1'b1, 1'b0, SIZE_BYTE, 1'b0, 32'h13, 32'h0, 5'd8, 2'b11), 1'b0, 1'b0, 1'b0); step();
        check_eq("t2_lb", bus.data_o, 32'hFFFFFF80);
        drive(mk(1'b1, 1'b0, SIZE_BYTE, 1'b1, 32'h13, 32'h0, 5'd8, 2'b11), 1'b0, 1'b0, 1'b0); step();
        check_eq("t2_lbu", bus.data_o, 32'h00000080);
        drive(lw(32'h10, 5'd8), 1'b0, 1'b0, 1'b0); step();
        check_eq("t2_word", bus.data_o, 32'h80ADBEEF);

        // Misaligned half store and word load.
        drive(sw(32'h20, 32'h5555AAAA), 1'b0, 1'b0, 1'b0); step();
        drive(mk(1'b0, 1'b1, SIZE_HALF, 1'b0, 32'h21, 32'hFFFF, 5'd0, 2'b00), 1'b0, 1'b0, 1'b0); step();
        check_eq("t3_sh_mis", 32'(bus.misalign_o), 32'h1);
        drive(lw(32'h22, 5'd9), 1'b0, 1'b0, 1'b0); step();
        check_eq("t3_lw_mis", 32'(bus.misalign_o), 32'h1);
        check_eq("t3_lw_data", bus.data_o, 32'h0);
        check_eq("t3_lw_wb", 32'(bus.WB_o), 32'h0);
        drive(lw(32'h20, 5'd9), 1'b0, 1'b0, 1'b0); step();
        check_eq("t3_unchanged", bus.data_o, 32'h5555AAAA);

        // Stalled store commits once on release.
        drive(sw(32'h40, 32'hCAFE0000), 1'b0, 1'b0, 1'b0); step();
        drive(sw(32'h40, 32'h00001234), 1'b0, 1'b0, 1'b0); step();
        for (int i = 0; i < 3; i++) begin
            drive(lw(32'h40, 5'd10), 1'b1, 1'b0, 1'b0); step();
            check_eq("t4_hold_addr", bus.addr_o, 32'h40);
        end
        drive(lw(32'h40, 5'd10), 1'b0, 1'b0, 1'b0); step();
        check_eq("t4_load", bus.data_o, 32'h00001234);

        // Flush, reset and flush-while-stalled all drop the store.
        drive(sw(32'h50, 32'h0BADF00D), 1'b0, 1'b0, 1'b0); step();
        drive(sw(32'h50, 32'hFFFFFFFF), 1'b0, 1'b1, 1'b0); step();
        check_eq("t5_flush_addr", bus.addr_o, 32'h0);
        check_eq("t5_flush_wb", 32'(bus.WB_o), 32'h0);
        drive(sw(32'h50, 32'h77777777), 1'b0, 1'b0, 1'b0); step();
        drive('0, 1'b0, 1'b0, 1'b1); step();
        check_eq("t5_rst_addr", bus.addr_o, 32'h0);
        drive(lw(32'h50, 5'd11), 1'b0, 1'b0, 1'b0); step();
        check_eq("t5_preserved", bus.data_o, 32'h0BADF00D);
        drive(sw(32'h50, 32'h66666666), 1'b0, 1'b0, 1'b0); step();
        drive('0, 1'b1, 1'b1, 1'b0); step();
        drive(lw(32'h50, 5'd11), 1'b0, 1'b0, 1'b0); step();
        check_eq("t5_stall_flush", bus.data_o, 32'h0BADF00D);

        // Address wrap modulo DEPTH.
        drive(sw(32'(DEPTH * 4 + 8), 32'hA5A5A5A5), 1'b0, 1'b0, 1'b0); step();
        drive(lw(32'h8, 5'd12), 1'b0, 1'b0, 1'b0); step();
        check_eq("t6_wrap", bus.data_o, 32'hA5A5A5A5);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 99));
            o.rd_en = (r < 40) || (r >= 90 && r < 95);
            o.wr_en = (r >= 40 && r < 80) || (r >= 90 && r < 95);
            o.size  = ($urandom_range(0, 9) == 0) ? SIZE_RSVD : 2'($urandom_range(0, 2));
            o.uns   = 1'($urandom);
            o.addr  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63));
            o.sdata = $urandom;
            o.rd    = 5'($urandom);
            o.wb    = 2'($urandom);
            drive(o, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5,
                  $urandom_range(0, 99) < 2);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
